irq_ctl: RTL and testbench
==========================

Name: irq_ctl

Overview:
- Interrupt controller that sequences the `irq` input of the beta CPU's PC unit.
- Collects NUM_SRC peripheral interrupt lines, edge-detects and latches them as pending, applies a mask and a fixed priority, and drives a single registered `irq`.
- Runs a claim/end-of-interrupt handshake with the CPU.
- Configured and queried through memory-mapped registers on the CPU data port (`memAddr`, `memWriteData`, `MemRead`, `MemWrite`).

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32).
- BASE_ADDR, 32'hFFFF_0000, register block base; must be 16-byte aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- src  input  NUM_SRC  interrupt request lines, rising-edge sensitive.
- irq  output  1  interrupt request to the PC unit.
- irq_ack  input  1  one-cycle pulse from the PC unit when the exception is taken.
- addr  input  32  CPU data address.
- wdata  input  32  CPU store data.
- we  input  1  CPU MemWrite.
- re  input  1  CPU MemRead.
- rdata  output  32  register read data; 0 when not selected.
- sel  output  1  high when `addr[31:4]==BASE_ADDR[31:4]` and (`re` or `we`); used by the top level to mux `rdata` into `memReadData`.

Behaviour:
- Reset: all of the following are cleared.
  - State IDLE; `irq`=0, `rdata`=0.
  - pending=0, mask=0 (all masked), enable=0, in_service vector=0, previous-sample register=0.
- Register map (offset = `addr[3:2]`):
  - 0 PENDING: read gives pending; a write clears the bits set in wdata (write-1-to-clear).
  - 1 MASK: read/write, bit=1 enables the source.
  - 2 VECTOR: read gives {enable_valid, 26'b0, in_service id[4:0]}; a write of any value is EOI.
  - 3 CTRL: bit0 = global enable, read/write; other bits read 0.
- `rdata` is combinational from the current register values. Writes take effect at the clock edge. Only word accesses are decoded; `addr[1:0]` is ignored.
- Edge detect: `prev <= src` each cycle. `pending[i]` is set at the edge where `src[i]=1` and `prev[i]=0`.
  - Set and W1C of the same bit in the same cycle: set wins.
- Candidate: lowest-index bit of (pending & mask). `cand_valid` = any such bit AND enable.
- FSM:
  - IDLE: if `cand_valid`, go to ASSERT. `irq` is registered, so it goes high one cycle after `cand_valid` is first true.
    - Overall latency: src rising at sample edge k → pending at k → `irq`=1 after edge k+1.
  - ASSERT: `irq`=1.
    - If `irq_ack`: latch the candidate id into in_service, clear that pending bit (the claim), go to SERVICE, `irq`=0 from the next cycle.
    - Else if `cand_valid` drops (masked, cleared, or disabled): go to IDLE, `irq`=0.
    - The candidate may change while in ASSERT; the id latched is the one present on the ack cycle.
  - SERVICE: `irq`=0; no nesting.
    - An EOI write returns to IDLE; if a candidate is still valid, IDLE re-asserts on the following cycle.
    - `irq_ack` is ignored.
- `irq_ack` in IDLE is ignored. An EOI write outside SERVICE is ignored.
- Edges arriving during SERVICE latch into pending normally. A repeated edge on an already-pending source is not counted (single bit).
- Reset asserted mid-operation immediately forces the reset state, including `irq`=0 asynchronously.

Optional Feature:
- IRQ_SYNC_EN
  - Defined: each `src` bit passes through a two-flop synchronizer before the edge detector. Edge-to-irq latency increases by 2 cycles. The synchronizer flops reset to 0.
  - Undefined: `src` feeds the edge detector directly; `src` is required to be synchronous to `clk`.

Decomposition:
- Package `irq_pkg`:
  - Register offset constants `IRQ_PENDING`=2'd0, `IRQ_MASK`=2'd1, `IRQ_VECTOR`=2'd2, `IRQ_CTRL`=2'd3.
  - FSM enum `irq_state_t` {IDLE, ASSERT, SERVICE}.
- One sub-module `prio_enc`: parameterised lowest-index-first encoder (in: NUM_SRC vector; out: valid, 5-bit id). Combinational, reused by the future DMA arbiter.

Test Plan:
1. Reset, write MASK=0x0F and CTRL=1, pulse `src[2]` for 1 cycle → PENDING reads 0x04; `irq`=1 two edges after the `src` sample; VECTOR unchanged until ack.
2. `src[5]` and `src[1]` rise together with MASK=0xFF → `irq_ack` claims id 1: VECTOR reads 1 and PENDING reads 0x20. EOI → `irq` re-asserts next cycle; second ack claims id 5.
3. Pending bit 3 with MASK bit 3=0 → `irq` stays 0. Write MASK=0x08 → `irq`=1. Write MASK=0 while in ASSERT → `irq`=0, FSM back to IDLE, PENDING still 0x08.
4. W1C of bit 4 in the same cycle as a new `src[4]` edge → PENDING bit 4 reads 1.
5. In SERVICE: `irq_ack` pulse and a `src[0]` edge → state unchanged and `irq`=0; PENDING bit0=1. After EOI, `irq`=1.
6. Assert `reset` asynchronously while in ASSERT → `irq`=0 without waiting for a clock edge; all registers read 0 after release. With IRQ_SYNC_EN defined, repeat test 1 → `irq` rises 2 cycles later.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: register offsets and FSM state type shared by the interrupt controller
package irq_pkg;
  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_MASK    = 2'd1;
  localparam logic [1:0] IRQ_VECTOR  = 2'd2;
  localparam logic [1:0] IRQ_CTRL    = 2'd3;
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} irq_state_t;
endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-index-first priority encoder
//   req   : request vector (N bits)
//   valid : any request set
//   id    : index of the lowest set request
module prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   id
);
  always_comb begin
    valid = |req;
    id = '0;
    for (int i = N - 1; i >= 0; i--) id = req[i] ? 5'(i) : id;
  end
endmodule

// File: rtl/irq_ctl.sv
// irq_ctl: edge-latched, masked, fixed-priority interrupt controller with claim/EOI handshake
//   clk, reset      : clock, asynchronous active-high reset
//   src             : rising-edge interrupt lines
//   irq / irq_ack   : request to the PC unit / exception-taken pulse
//   addr, wdata, we, re, rdata, sel : memory-mapped register port
//   Optional macro IRQ_SYNC_EN adds a two-flop synchronizer on src.
module irq_ctl
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  input  logic               irq_ack,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               we,
  input  logic               re,
  output logic [31:0]        rdata,
  output logic               sel
);
  logic [NUM_SRC-1:0] src_e, rise, w1c, claim_bit;
  logic [NUM_SRC-1:0] prev_q, prev_d, pending_q, pending_d, mask_q, mask_d;
  logic               enable_q, enable_d;
  logic [4:0]         in_service_q, in_service_d, cand_id;
  logic               cand_any, cand_valid, wr, eoi, claim;
  logic [1:0]         off;
  irq_state_t         state_q, state_d;
  logic               unused_ok;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) {sync2_q, sync1_q} <= '0;
    else       {sync2_q, sync1_q} <= {sync1_q, src};
  assign src_e = sync2_q;
`else
  assign src_e = src;
`endif

  prio_enc #(.N(NUM_SRC)) u_prio (
    .req  (pending_q & mask_q),
    .valid(cand_any),
    .id   (cand_id)
  );

  assign unused_ok  = ^{addr[1:0], wdata};
  assign off        = addr[3:2];
  assign sel        = (addr[31:4] == BASE_ADDR[31:4]) && (re || we);
  assign wr         = sel && we;
  assign cand_valid = cand_any && enable_q;
  assign claim      = (state_q == ASSERT) && irq_ack && cand_valid;
  assign eoi        = wr && (off == IRQ_VECTOR) && (state_q == SERVICE);

  always_comb begin
    rise = src_e & ~prev_q;
    w1c = (wr && off == IRQ_PENDING) ? wdata[NUM_SRC-1:0] : '0;
    for (int i = 0; i < NUM_SRC; i++) claim_bit[i] = claim && (cand_id == 5'(i));
    prev_d = src_e;
    // a new edge outranks a same-cycle clear so no request is lost
    pending_d = (pending_q & ~w1c & ~claim_bit) | rise;
    mask_d = (wr && off == IRQ_MASK) ? wdata[NUM_SRC-1:0] : mask_q;
    enable_d = (wr && off == IRQ_CTRL) ? wdata[0] : enable_q;
    in_service_d = claim ? cand_id : in_service_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      enable_q     <= 1'b0;
      in_service_q <= '0;
    end else begin
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      enable_q     <= enable_d;
      in_service_q <= in_service_d;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb
    state_d = (state_q == IDLE)   ? (cand_valid ? ASSERT : IDLE) :
              (state_q == ASSERT) ? (claim ? SERVICE : cand_valid ? ASSERT : IDLE) :
                                    (eoi ? IDLE : SERVICE);

  always_comb
    irq = (state_q == ASSERT);

  always_comb
    rdata = !sel                ? '0 :
            off == IRQ_PENDING  ? 32'(pending_q) :
            off == IRQ_MASK     ? 32'(mask_q) :
            off == IRQ_VECTOR   ? {cand_valid, 26'b0, in_service_q} :
                                  {31'b0, enable_q};
endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: self-checking bench for irq_ctl with a read-expectation scoreboard
module tb_irq_ctl;
  import irq_pkg::*;
`ifdef IRQ_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 0, reset = 1, irq_ack = 0, we = 0, re = 0, irq, sel;
  logic [7:0]  src = '0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [31:0] exp_q[$];
  logic [31:0] v, e;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  irq_ctl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .irq(irq), .irq_ack(irq_ack),
    .addr(addr), .wdata(wdata), .we(we), .re(re), .rdata(rdata), .sel(sel)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    addr = BASE | {28'b0, off, 2'b0};
    wdata = d;
    we = 1;
    tick;
    we = 0;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
    addr = BASE | {28'b0, off, 2'b0};
    re = 1;
    #1;
    d = rdata;
    re = 0;
    #1;
  endtask

  task automatic pulse(input logic [7:0] s);
    src = s;
    tick;
    src = '0;
    repeat (SYNC) tick;
  endtask

  task automatic ack;
    irq_ack = 1;
    tick;
    irq_ack = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset = 0;
    tick;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v); e = exp_q.pop_front();
      checks++; if (v !== e) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", i, v, e); end
    end
    addr = BASE; re = 1; #1;
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_hit: got %b want 1", sel); end
    addr = 32'h1234_0000; #1;
    checks++; if (sel !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL sel_miss: got sel=%b rdata=%h want 0/0", sel, rdata); end
    re = 0;
  endtask

  task automatic test_basic;
    bus_write(IRQ_MASK, 32'h0F);
    bus_write(IRQ_CTRL, 32'hFFFF_FFFF);
    exp_q.push_back(32'h1);
    bus_read(IRQ_CTRL, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t1_ctrl: got %h want %h", v, e); end
    pulse(8'h04);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t1_irq_early: got %b want 0", irq); end
    exp_q.push_back(32'h04); exp_q.push_back(32'h8000_0000);
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t1_pending: got %h want %h", v, e); end
    bus_read(IRQ_VECTOR, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t1_vector_pre: got %h want %h", v, e); end
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t1_irq_rise: got %b want 1", irq); end
    ack;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t1_irq_after_ack: got %b want 0", irq); end
    exp_q.push_back(32'h2); exp_q.push_back(32'h0);
    bus_read(IRQ_VECTOR, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t1_vector_claim: got %h want %h", v, e); end
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t1_pending_claim: got %h want %h", v, e); end
    bus_write(IRQ_VECTOR, 32'h0);
    tick;
    checks++; if (irq !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL t1_eoi_idle: got irq=%b state=%0d want 0/IDLE", irq, dut.state_q); end
  endtask

  task automatic test_priority;
    bus_write(IRQ_MASK, 32'hFF);
    pulse(8'h22);
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t2_irq: got %b want 1", irq); end
    ack;
    exp_q.push_back(32'h8000_0001); exp_q.push_back(32'h20);
    bus_read(IRQ_VECTOR, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t2_vector1: got %h want %h", v, e); end
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t2_pending1: got %h want %h", v, e); end
    bus_write(IRQ_VECTOR, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t2_irq_eoi: got %b want 0", irq); end
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t2_irq_reassert: got %b want 1", irq); end
    ack;
    exp_q.push_back(32'h5); exp_q.push_back(32'h0);
    bus_read(IRQ_VECTOR, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t2_vector5: got %h want %h", v, e); end
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t2_pending5: got %h want %h", v, e); end
    bus_write(IRQ_VECTOR, 32'h0);
  endtask

  task automatic test_mask;
    bus_write(IRQ_MASK, 32'h0);
    pulse(8'h08);
    repeat (2) tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t3_masked_irq: got %b want 0", irq); end
    bus_write(IRQ_MASK, 32'h08);
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t3_unmasked_irq: got %b want 1", irq); end
    bus_write(IRQ_MASK, 32'h0);
    tick;
    checks++; if (irq !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL t3_remask: got irq=%b state=%0d want 0/IDLE", irq, dut.state_q); end
    exp_q.push_back(32'h08); exp_q.push_back(32'h5);
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t3_pending: got %h want %h", v, e); end
    bus_read(IRQ_VECTOR, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t3_vector: got %h want %h", v, e); end
    bus_write(IRQ_PENDING, 32'h08);
  endtask

  task automatic test_w1c_race;
    pulse(8'h10);
    tick;
    exp_q.push_back(32'h10);
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t4_pending_set: got %h want %h", v, e); end
    src = 8'h10;
    for (int i = 0; i < SYNC; i++) begin tick; src = '0; end
    bus_write(IRQ_PENDING, 32'h10);
    src = '0;
    exp_q.push_back(32'h10);
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t4_set_wins: got %h want %h", v, e); end
    repeat (SYNC + 1) tick;
    bus_write(IRQ_PENDING, 32'h10);
    exp_q.push_back(32'h0);
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t4_w1c: got %h want %h", v, e); end
  endtask

  task automatic test_service;
    bus_write(IRQ_MASK, 32'hFF);
    pulse(8'h40);
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t5_irq: got %b want 1", irq); end
    ack;
    src = 8'h01; irq_ack = 1;
    tick;
    src = '0; irq_ack = 0;
    repeat (SYNC) tick;
    tick;
    checks++; if (irq !== 1'b0 || dut.state_q !== SERVICE) begin errors++; $display("FAIL t5_service_hold: got irq=%b state=%0d want 0/SERVICE", irq, dut.state_q); end
    exp_q.push_back(32'h01); exp_q.push_back(32'h8000_0006);
    bus_read(IRQ_PENDING, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t5_pending: got %h want %h", v, e); end
    bus_read(IRQ_VECTOR, v); e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL t5_vector: got %h want %h", v, e); end
    bus_write(IRQ_VECTOR, 32'h0);
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t5_irq_after_eoi: got %b want 1", irq); end
    ack;
    bus_write(IRQ_VECTOR, 32'h0);
  endtask

  task automatic test_async_reset;
    pulse(8'h80);
    tick;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL t6_irq_pre: got %b want 1", irq); end
    #2 reset = 1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t6_async_irq: got %b want 0", irq); end
    #2 reset = 0;
    tick;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'(i), v); e = exp_q.pop_front();
      checks++; if (v !== e) begin errors++; $display("FAIL t6_reg%0d: got %h want %h", i, v, e); end
    end
    tick;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL t6_irq_post: got %b want 0", irq); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_mask;
    test_w1c_race;
    test_service;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
